clocked_gate_n: RTL

CLOCKED_GATE_N -- requirements
Module: clocked_gate_n

---
 rtl/clocked_gate_n.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/clocked_gate_n.sv
// clocked_gate_n
//   Pulse-combining gate. Rising edges on each in_p line set a per-line state
//   bit; the rising edge of eval combines those bits (AND/OR/XOR selected by
//   OP) and queues the result into a delay line. A 1 leaving the delay line
//   produces a PULSE_W-cycle pulse on out. An input edge that lands on or
//   within GUARD cycles after an eval edge marks that line bad. The next
//   evaluation is then forced to 0 and flagged on viol/viol_cnt.
//
// Ports
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   in_p     : N_IN input pulse lines
//   eval     : evaluation strobe (rising edge only)
//   out      : registered result pulse
//   viol     : registered one-cycle hold-violation flag
//   viol_cnt : saturating count of violating evaluations
module clocked_gate_n #(
  parameter int N_IN      = 2,
  parameter int OP        = 0,
  parameter int OUT_DELAY = 2,
  parameter int PULSE_W   = 2,
  parameter int GUARD     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in_p,
  input  logic            eval,
  output logic            out,
  output logic            viol,
  output logic [7:0]      viol_cnt
);

  logic [N_IN-1:0] in_prev_q;
  logic [N_IN-1:0] s_q, s_d;
  logic [N_IN-1:0] b_q, b_d;
  logic [N_IN-1:0] in_edge;
  logic            eval_prev_q;
  logic            eval_edge;
  logic [3:0]      guard_q, guard_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            out_q, out_d;
  logic            viol_q, viol_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            red;
  logic            r;
  logic            emerge;

  always_comb begin
    in_edge   = in_p & ~in_prev_q;
    eval_edge = eval & ~eval_prev_q;

    case (OP)
      0:       red = &s_q;
      1:       red = |s_q;
      default: red = ^s_q;
    endcase

    // Reduction uses the state from before this cycle's input edges.
    r = eval_edge & ~(|b_q) & red;

    if (eval_edge) begin
      guard_d = 4'(GUARD);
    end else if (guard_q != 4'd0) begin
      guard_d = guard_q - 4'd1;
    end else begin
      guard_d = '0;
    end

    // Edges coinciding with an eval edge open the next window already bad.
    if (eval_edge) begin
      s_d = in_edge;
      b_d = in_edge;
    end else begin
      s_d = s_q | in_edge;
      b_d = (guard_q != 4'd0) ? (b_q | in_edge) : b_q;
    end

    viol_d = eval_edge & (|b_q);
    cnt_d  = cnt_q;
    if (viol_d && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end

    // A 1 leaving the delay line (re)loads the width; a 0 never cuts a pulse.
    if (emerge) begin
      out_d  = 1'b1;
      wcnt_d = 4'(PULSE_W - 1);
    end else if (wcnt_q != 4'd0) begin
      out_d  = 1'b1;
      wcnt_d = wcnt_q - 4'd1;
    end else begin
      out_d  = 1'b0;
      wcnt_d = '0;
    end
  end

  // out_q is itself the last delay stage, so only OUT_DELAY-1 extra stages.
  if (OUT_DELAY == 1) begin : g_nodly
    assign emerge = r;
  end else begin : g_dly
    logic [OUT_DELAY-2:0] dl_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        dl_q <= '0;
      end else begin
        dl_q[0] <= r;
        for (int unsigned k = 1; k < OUT_DELAY - 1; k++) begin
          dl_q[k] <= dl_q[k-1];
        end
      end
    end
    assign emerge = dl_q[OUT_DELAY-2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_prev_q   <= '0;
      eval_prev_q <= 1'b0;
      s_q         <= '0;
      b_q         <= '0;
      guard_q     <= '0;
      wcnt_q      <= '0;
      out_q       <= 1'b0;
      viol_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      in_prev_q   <= in_p;
      eval_prev_q <= eval;
      s_q         <= s_d;
      b_q         <= b_d;
      guard_q     <= guard_d;
      wcnt_q      <= wcnt_d;
      out_q       <= out_d;
      viol_q      <= viol_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out      = out_q;
  assign viol     = viol_q;
  assign viol_cnt = cnt_q;

endmodule
